// File: rtl/ac_exec_ctrl.sv
// Multi-cycle execution controller for the basic-computer accumulator datapath.
// Owns AC, E and DR; sequences operand fetch, ALU execution and writeback.
module ac_exec_ctrl #(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [2:0]        alu_opsel,
  output logic [WIDTH-1:0]  alu_ac,
  output logic [WIDTH-1:0]  alu_dr,
  output logic              alu_e,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [1:0]        alu_cntrl_e,
  output logic [WIDTH-1:0]  ac,
  output logic              e,
  output logic              done,
  output logic              skip,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] SEL_NOP = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_EXEC} state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,  OP_ADD = 4'd1,  OP_LDA = 4'd2,  OP_CLA = 4'd3,
    OP_CLE = 4'd4,  OP_CMA = 4'd5,  OP_CME = 4'd6,  OP_CIR = 4'd7,
    OP_CIL = 4'd8,  OP_INC = 4'd9,  OP_SPA = 4'd10, OP_SNA = 4'd11,
    OP_SZA = 4'd12, OP_SZE = 4'd13, OP_I14 = 4'd14, OP_I15 = 4'd15
  } op_t;

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     wait_cnt;
  logic [WIDTH-1:0]  dr_q;
  logic              dr_one;

  function automatic logic [2:0] opsel_of(input op_t op);
    case (op)
      OP_AND:         return 3'b001;
      OP_ADD, OP_INC: return 3'b000;
      OP_LDA:         return 3'b010;
      OP_CMA:         return 3'b011;
      OP_CIR:         return 3'b100;
      OP_CIL:         return 3'b101;
      default:        return SEL_NOP;
    endcase
  endfunction

  // 10 sets E, 01 clears E, anything else holds it.
  function automatic logic e_update(input logic [1:0] ctl, input logic cur);
    case (ctl)
      2'b10:   return 1'b1;
      2'b01:   return 1'b0;
      default: return cur;
    endcase
  endfunction

  assign cmd_ready = (state == S_IDLE) && !rst;
  assign mem_addr  = addr_q;
  assign alu_ac    = ac;
  assign alu_e     = e;
  assign alu_dr    = dr_one ? WIDTH'(1) : dr_q;

  // NOTE: all state is assigned with <= so every register samples pre-edge values;
  // blocking assignments here would create order-dependent simulation/synthesis mismatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      op_q      <= OP_AND;
      addr_q    <= '0;
      wait_cnt  <= '0;
      dr_q      <= '0;
      dr_one    <= 1'b0;
      ac        <= '0;
      e         <= 1'b0;
      mem_req   <= 1'b0;
      alu_opsel <= SEL_NOP;
      done      <= 1'b0;
      skip      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      skip <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q     <= op_t'(cmd_op);
            addr_q   <= cmd_addr;
            wait_cnt <= '0;
            if (cmd_op <= 4'd2) begin
              state   <= S_MEM;
              mem_req <= 1'b1;
            end else begin
              state     <= S_EXEC;
              alu_opsel <= opsel_of(op_t'(cmd_op));
              dr_one    <= (op_t'(cmd_op) == OP_INC);
            end
          end
        end

        S_MEM: begin
          if (mem_ack) begin
            dr_q      <= mem_rdata;
            mem_req   <= 1'b0;
            state     <= S_EXEC;
            alu_opsel <= opsel_of(op_q);
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
            done    <= 1'b1;
            err     <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_EXEC: begin
          state     <= S_IDLE;
          done      <= 1'b1;
          alu_opsel <= SEL_NOP;
          dr_one    <= 1'b0;
          case (op_q)
            OP_AND, OP_LDA, OP_CMA, OP_INC: ac <= alu_result;
            OP_ADD, OP_CIR, OP_CIL: begin
              ac <= alu_result;
              e  <= e_update(alu_cntrl_e, e);
            end
            OP_CLA: ac <= '0;
            OP_CLE: e  <= 1'b0;
            OP_CME: e  <= ~e;
            OP_SPA: skip <= !ac[WIDTH-1] && (ac != '0);
            OP_SNA: skip <= ac[WIDTH-1];
            OP_SZA: skip <= (ac == '0);
            OP_SZE: skip <= !e;
            OP_I14, OP_I15: err <= 1'b1;
            default: ;
          endcase
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ac_exec_ctrl.sv
// Self-checking bench for ac_exec_ctrl: behavioural ALU/memory around the DUT
// and an arithmetic reference model of AC, E and DR.
module tb_ac_exec_ctrl;

  localparam int WIDTH   = 16;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WIDTH-1:0]  mem_rdata;
  logic [2:0]        alu_opsel;
  logic [WIDTH-1:0]  alu_ac, alu_dr, alu_result;
  logic              alu_e;
  logic [1:0]        alu_cntrl_e;
  logic [WIDTH-1:0]  ac;
  logic              e, done, skip, err;

  ac_exec_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .alu_opsel(alu_opsel),
    .alu_ac(alu_ac), .alu_dr(alu_dr), .alu_e(alu_e), .alu_result(alu_result),
    .alu_cntrl_e(alu_cntrl_e), .ac(ac), .e(e), .done(done), .skip(skip), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU. Ops that must not touch E get an E-control that would flip it.
  logic [WIDTH:0] alu_sum;
  logic [1:0]     junk_e;
  always_comb begin
    alu_sum     = {1'b0, alu_ac} + {1'b0, alu_dr};
    junk_e      = alu_e ? 2'b01 : 2'b10;
    alu_result  = alu_ac ^ 16'hA5A5;
    alu_cntrl_e = junk_e;
    case (alu_opsel)
      3'b000: begin
        alu_result  = alu_sum[WIDTH-1:0];
        alu_cntrl_e = alu_sum[WIDTH] ? 2'b10 : 2'b01;
      end
      3'b001: alu_result = alu_ac & alu_dr;
      3'b010: alu_result = alu_dr;
      3'b011: alu_result = ~alu_ac;
      3'b100: begin
        alu_result  = {alu_e, alu_ac[WIDTH-1:1]};
        alu_cntrl_e = alu_ac[0] ? 2'b10 : 2'b01;
      end
      3'b101: begin
        alu_result  = {alu_ac[WIDTH-2:0], alu_e};
        alu_cntrl_e = alu_ac[WIDTH-1] ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

  logic [WIDTH-1:0] ac_m, dr_m;
  logic             e_m;
  int               n_tests = 0;
  int               n_fail  = 0;

  // Issue one command (caller is just after a negedge with cmd_ready expected high),
  // serve memory with `delay` wait cycles (negative = never ack), check the done cycle.
  task automatic run_cmd(input logic [3:0] op, input logic [ADDR_W-1:0] addr,
                         input logic [WIDTH-1:0] data, input int delay,
                         input string name, output int done_at);
    logic [WIDTH-1:0] ac_x;
    logic [WIDTH:0]   s;
    logic             e_x, skip_x, err_x, mem_op, tmo, seen, side_bad;
    logic [2:0]       sel_x, last_sel;
    int               lat_x, req_x, k, reqs;

    mem_op = (op <= 4'd2);
    tmo    = mem_op && (delay < 0 || delay >= TIMEOUT);
    ac_x = ac_m; e_x = e_m; skip_x = 1'b0; err_x = 1'b0;
    if (tmo) err_x = 1'b1;
    else begin
      if (mem_op) dr_m = data;
      case (op)
        4'd0:  ac_x = ac_m & dr_m;
        4'd1:  begin s = ac_m + dr_m; ac_x = s[WIDTH-1:0]; e_x = s[WIDTH]; end
        4'd2:  ac_x = dr_m;
        4'd3:  ac_x = '0;
        4'd4:  e_x = 1'b0;
        4'd5:  ac_x = ~ac_m;
        4'd6:  e_x = ~e_m;
        4'd7:  begin ac_x = (ac_m >> 1) | (WIDTH'(e_m) << (WIDTH-1)); e_x = ac_m[0]; end
        4'd8:  begin ac_x = (ac_m << 1) | WIDTH'(e_m); e_x = ac_m[WIDTH-1]; end
        4'd9:  ac_x = ac_m + 1;
        4'd10: skip_x = ($signed(ac_m) > 0);
        4'd11: skip_x = ($signed(ac_m) < 0);
        4'd12: skip_x = (ac_m == 0);
        4'd13: skip_x = (e_m == 0);
        default: err_x = 1'b1;
      endcase
    end
    case (op)
      4'd0: sel_x = 3'b001;  4'd1: sel_x = 3'b000;  4'd2: sel_x = 3'b010;
      4'd5: sel_x = 3'b011;  4'd7: sel_x = 3'b100;  4'd8: sel_x = 3'b101;
      4'd9: sel_x = 3'b000;  default: sel_x = 3'b111;
    endcase
    lat_x = !mem_op ? 2 : (tmo ? TIMEOUT + 1 : delay + 3);
    req_x = !mem_op ? 0 : (tmo ? TIMEOUT : delay + 1);

    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_at_issue: got %b want 1", name, cmd_ready);
    end
    @(posedge clk); #1 cmd_valid = 1'b0;
    cmd_op = 4'($urandom);
    k = 0; reqs = 0; seen = 1'b0; side_bad = 1'b0; last_sel = 3'b111;
    while (!seen && k < 60) begin
      @(negedge clk); k++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (mem_req === 1'b1) begin
          reqs++;
          if (mem_addr !== addr || alu_opsel !== 3'b111) side_bad = 1'b1;
          mem_ack   = (reqs - 1 == delay);
          mem_rdata = mem_ack ? data : WIDTH'($urandom);
        end else begin
          mem_ack   = 1'($urandom);
          mem_rdata = WIDTH'($urandom);
        end
        last_sel = alu_opsel;
      end
    end
    mem_ack = 1'b0;
    done_at = cyc;

    n_tests++;
    if (!seen || k != lat_x) begin
      n_fail++; $display("FAIL %s latency: got %0d (done seen %b) want %0d", name, k, seen, lat_x);
    end
    n_tests++;
    if (ac !== ac_x || e !== e_x) begin
      n_fail++; $display("FAIL %s ac_e: got %h/%b want %h/%b", name, ac, e, ac_x, e_x);
    end
    n_tests++;
    if (skip !== skip_x || err !== err_x) begin
      n_fail++; $display("FAIL %s skip_err: got %b/%b want %b/%b", name, skip, err, skip_x, err_x);
    end
    n_tests++;
    if (alu_dr !== dr_m) begin
      n_fail++; $display("FAIL %s dr: got %h want %h", name, alu_dr, dr_m);
    end
    n_tests++;
    if (reqs != req_x || side_bad) begin
      n_fail++; $display("FAIL %s mem_req_cycles: got %0d (addr/opsel bad %b) want %0d", name, reqs, side_bad, req_x);
    end
    n_tests++;
    if (!tmo && last_sel !== sel_x) begin
      n_fail++; $display("FAIL %s exec_opsel: got %b want %b", name, last_sel, sel_x);
    end
    n_tests++;
    if (cmd_ready !== 1'b1 || mem_req !== 1'b0 || alu_opsel !== 3'b111) begin
      n_fail++; $display("FAIL %s done_cycle_idle: ready %b req %b opsel %b", name, cmd_ready, mem_req, alu_opsel);
    end
    ac_m = ac_x; e_m = e_x;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (ac !== 16'h0000 || e !== 1'b0 || mem_req !== 1'b0 || alu_opsel !== 3'b111 ||
        done !== 1'b0 || skip !== 1'b0 || err !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ac %h e %b req %b opsel %b done %b skip %b err %b ready %b",
               ac, e, mem_req, alu_opsel, done, skip, err, cmd_ready);
    end
    rst = 1'b0; #1;
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
    ac_m = '0; e_m = 1'b0; dr_m = '0;
  endtask

  task automatic test_memory_ops();
    int t;
    run_cmd(4'd2, 12'h010, 16'hFFFF, 2, "lda_wait2", t);
    n_tests++;
    if (ac !== 16'hFFFF) begin
      n_fail++; $display("FAIL lda_value: got %h want ffff", ac);
    end
    run_cmd(4'd1, 12'h011, 16'h0001, 0, "add_wrap", t);
    n_tests++;
    if (ac !== 16'h0000 || e !== 1'b1) begin
      n_fail++; $display("FAIL add_wrap_value: got %h/%b want 0000/1", ac, e);
    end
  endtask

  task automatic test_shift_skip_inc();
    int t;
    run_cmd(4'd2, 12'h020, 16'h0001, 1, "lda_one", t);
    run_cmd(4'd4, 12'h000, 16'h0000, 0, "cle", t);
    run_cmd(4'd7, 12'h000, 16'h0000, 0, "cir", t);
    n_tests++;
    if (ac !== 16'h0000 || e !== 1'b1) begin
      n_fail++; $display("FAIL cir_value: got %h/%b want 0000/1", ac, e);
    end
    run_cmd(4'd12, 12'h000, 16'h0000, 0, "sza", t);
    run_cmd(4'd9, 12'h000, 16'h0000, 0, "inc", t);
    n_tests++;
    if (ac !== 16'h0001 || e !== 1'b1) begin
      n_fail++; $display("FAIL inc_value: got %h/%b want 0001/1", ac, e);
    end
  endtask

  task automatic test_timeout();
    int t;
    run_cmd(4'd0, 12'h3A5, 16'h0000, -1, "and_timeout", t);
    run_cmd(4'd2, 12'h7FF, 16'h1234, TIMEOUT - 1, "lda_last_wait", t);
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2, t3;
    run_cmd(4'd2, 12'h040, 16'h00F0, 0, "lda_f0", t0);
    run_cmd(4'd4, 12'h000, 16'h0000, 0, "cle_b2b", t0);
    run_cmd(4'd5, 12'h000, 16'h0000, 0, "cma_b2b", t1);
    n_tests++;
    if (ac !== 16'hFF0F) begin
      n_fail++; $display("FAIL cma_value: got %h want ff0f", ac);
    end
    run_cmd(4'd6, 12'h000, 16'h0000, 0, "cme_b2b", t2);
    run_cmd(4'd15, 12'h000, 16'h0000, 0, "ill15_b2b", t3);
    n_tests++;
    if (t1 - t0 != 2 || t2 - t1 != 2 || t3 - t2 != 2) begin
      n_fail++; $display("FAIL b2b_done_spacing: got %0d,%0d,%0d want 2,2,2", t1 - t0, t2 - t1, t3 - t2);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    run_cmd(4'd2, 12'h050, 16'h1234, 0, "lda_pre_abort", t);
    cmd_valid = 1'b1; cmd_op = 4'd1; cmd_addr = 12'h055;
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'd3; cmd_addr = 12'h0AA;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 12'h055 || done !== 1'b0) begin
      n_fail++; $display("FAIL busy_valid_ignored: req %b addr %h done %b want 1/055/0", mem_req, mem_addr, done);
    end
    cmd_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b0 || ac !== 16'h0000 || e !== 1'b0 || done !== 1'b0 ||
        alu_dr !== 16'h0000 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_mem: req %b ac %h e %b done %b dr %h ready %b",
                         mem_req, ac, e, done, alu_dr, cmd_ready);
    end
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || mem_req !== 1'b0 || ac !== 16'h0000 || cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL post_abort_quiet: done %b req %b ac %h ready %b", done, mem_req, ac, cmd_ready);
      end
    end
    mem_ack = 1'b0;
    ac_m = '0; e_m = 1'b0; dr_m = '0;
  endtask

  task automatic test_random();
    int t, r, dly;
    logic [3:0] op;
    for (int i = 0; i < 60; i++) begin
      op  = 4'($urandom_range(0, 15));
      r   = $urandom_range(0, 9);
      dly = (r == 0) ? -1 : (r % 4);
      run_cmd(op, 12'($urandom), 16'($urandom), dly, $sformatf("rand%0d_op%0d", i, op), t);
    end
  endtask

  initial begin
    test_reset();
    test_memory_ops();
    test_shift_skip_inc();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ac_exec_ctrl.md
# ac_exec_ctrl

Multi-cycle execution controller for the accumulator datapath of the basic computer. Owns the AC, E and DR registers. Accepts one decoded AC/E instruction at a time over a valid/ready handshake, fetches the memory operand when needed, and drives the external ALU's operand and operation-select inputs. Writes back the ALU result and the ALU's E-control, then pulses `done`. Sits between the instruction decoder and the ALU/memory port.

## Interface
- `WIDTH`, 16, data width of AC, DR and the ALU.
- `ADDR_W`, 12, memory address width.
- `TIMEOUT`, 15, maximum cycles to wait for `mem_ack` in MEM state (must be ≥1).

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: instruction offered.
- `cmd_ready` out 1: controller can accept.
- `cmd_op` in 4: operation code (see Operation).
- `cmd_addr` in ADDR_W: operand address for memory ops.
- `mem_req` out 1: memory read request.
- `mem_addr` out ADDR_W: read address.
- `mem_ack` in 1: read data valid this cycle.
- `mem_rdata` in WIDTH: read data.
- `alu_opsel` out 3: ALU op select; 3'b111 = NOP.
- `alu_ac` out WIDTH: ALU A operand.
- `alu_dr` out WIDTH: ALU B operand.
- `alu_e` out 1: ALU E input.
- `alu_result` in WIDTH: ALU result.
- `alu_cntrl_e` in 2: E control from the ALU; 10 sets E, 01 clears E, 00/11 leave E unchanged.
- `ac` out WIDTH: accumulator register.
- `e` out 1: E flag register.
- `done` out 1: one-cycle completion pulse.
- `skip` out 1: valid with `done`; the skip condition was true.
- `err` out 1: valid with `done`; illegal op or memory timeout.

## Operation
- States: IDLE, MEM, EXEC.
- IDLE: `cmd_ready`=1. On `cmd_valid`&`cmd_ready`, latch op and address. Memory ops (0–2) go to MEM; ops 3–15 go to EXEC.
- MEM:
  - `mem_req`=1 and `mem_addr`=latched address, held constant.
  - On `mem_ack`=1: DR←`mem_rdata`, go to EXEC.
  - A wait counter starts at 0 on entry. If `mem_ack` is not seen within TIMEOUT cycles, go to IDLE with `done`=1 and `err`=1; AC, E and DR are unchanged.
- EXEC lasts one cycle. `alu_opsel` is driven per op, and the writeback happens on the closing edge:
  - 0 AND: opsel 001; AC←result.
  - 1 ADD: opsel 000; AC←result; E per `alu_cntrl_e`.
  - 2 LDA: opsel 010; AC←result.
  - 3 CLA: opsel 111; AC←0.
  - 4 CLE: opsel 111; E←0.
  - 5 CMA: opsel 011; AC←result.
  - 6 CME: opsel 111; E←~E.
  - 7 CIR: opsel 100; AC←result; E per `alu_cntrl_e`.
  - 8 CIL: opsel 101; AC←result; E per `alu_cntrl_e`.
  - 9 INC: opsel 000 with `alu_dr` forced to 1; AC←result; E unchanged (`alu_cntrl_e` ignored).
  - 10 SPA: `skip`=(AC[WIDTH-1]==0 && AC!=0).
  - 11 SNA: `skip`=AC[WIDTH-1].
  - 12 SZA: `skip`=(AC==0).
  - 13 SZE: `skip`=(E==0).
  - For ops 10–13, opsel is 111 and AC/E are unchanged.
  - 14, 15: illegal; `err`=1, no state change.
- After EXEC, go to IDLE and assert `done` the next cycle.
- `alu_opsel`=111 in every state other than EXEC, and in EXEC for ops 3, 4, 6 and 10–15.
- `alu_ac`=AC, `alu_e`=E and `alu_dr`=DR at all times, except `alu_dr`=1 during EXEC of INC.
- Arithmetic: all AC updates are modulo 2^WIDTH. Carry and overflow are not stored except through `alu_cntrl_e`.

## Timing
- Reset values: AC=0, E=0, DR=0, state IDLE, `mem_req`=0, `done`=0, `skip`=0, `err`=0, `alu_opsel`=111.
- `cmd_ready`=0 in any cycle where `rst`=1.
- `done`, `skip` and `err` are registered and high for exactly one cycle, in the cycle after EXEC (or after timeout). In that cycle the updated AC/E are already visible and state is IDLE.
- `cmd_ready`=1 in the `done` cycle, so back-to-back commands are allowed.
- Latency from the accept edge:
  - Register ops: EXEC in the next cycle; `done` 2 cycles after accept.
  - Memory ops with `mem_ack` on the first MEM cycle: `done` 3 cycles after accept; each wait cycle adds 1.
- `mem_ack` is only honoured in MEM; it is ignored in all other states.
- Reset mid-operation (MEM or EXEC): the op is aborted. After the edge, all values are at reset, with no `done` and no writeback.
- `cmd_valid` while busy (`cmd_ready`=0) is ignored and not queued.

## Test plan
- Reset: assert `rst` 2 cycles → AC=0x0000, E=0, `mem_req`=0, `alu_opsel`=111, `done`=0; `cmd_ready`=1 on the first cycle after release.
- LDA addr 0x010 (mem=0xFFFF, ack after 2 wait cycles), then ADD addr 0x011 (mem=0x0001, immediate ack):
  - LDA → `done` 5 cycles after accept, AC=0xFFFF.
  - ADD → AC=0x0000, E=1, `done` 3 cycles after accept.
- With AC=0x0001, E=0:
  - CIR → AC=0x0000, E=1.
  - Then SZA → `done`=1, `skip`=1.
  - Then INC → AC=0x0001, E stays 1.
- Memory op with `mem_ack` held low → `mem_req` high for exactly TIMEOUT cycles, then `done`=1 and `err`=1; AC, E and DR unchanged.
- Back-to-back CMA, CME, op 15, issued on consecutive ready cycles from AC=0x00F0, E=0:
  - CMA → AC=0xFF0F.
  - CME → E=1.
  - op 15 → `err`=1 with AC/E unchanged.
  - `done` pulses every 2 cycles.
- `rst` asserted during MEM of an ADD → next cycle `mem_req`=0, AC=0, E=0, no `done`.
- `cmd_valid` pulsed during that MEM cycle → ignored.
